// File: rtl/axi4_wr_aux_arb_pkg.sv
// Shared types and helpers for the write-aux request arbiter: FSM state
// encoding and the round-robin next-index function.
package axi4_wr_aux_arb_pkg;

    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_e;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W:0]   num);
        logic [IDX_W:0] nxt;
        nxt = {1'b0, idx} + {{IDX_W{1'b0}}, 1'b1};
        return (nxt >= num) ? {IDX_W{1'b0}} : nxt[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/axi4_wr_aux_arbiter_rr_pick.sv
// Combinational round-robin selector: the first requester at or above ptr,
// wrapping modulo NUM, receives a one-hot grant.
module rr_pick
    import axi4_wr_aux_arb_pkg::*;
#(
    parameter int NUM = 4,
    parameter int PW  = 2
) (
    input  logic [NUM-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NUM-1:0] gnt
);

    logic          found_s;
    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;

    // Walk the requesters in priority order starting at ptr; the first hit masks the rest.
    always_comb begin
        gnt     = {NUM{1'b0}};
        found_s = 1'b0;
        sum_s   = {(PW+1){1'b0}};
        idx_s   = {PW{1'b0}};
        for (int i = 0; i < NUM; i++) begin
            sum_s      = {1'b0, ptr} + (PW+1)'(i);
            idx_s      = (sum_s >= (PW+1)'(NUM)) ? PW'(sum_s - (PW+1)'(NUM)) : PW'(sum_s);
            gnt[idx_s] = req[idx_s] & ~found_s;
            found_s    = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/axi4_wr_aux_arbiter.sv
// Round-robin arbiter feeding one {id,addr,len} request at a time to the wr-aux
// generator; optional response watchdog enabled by AXI4_WR_AUX_ARB_TIMEOUT_EN.
module axi4_wr_aux_arbiter
    import axi4_wr_aux_arb_pkg::*;
#(
    parameter int NUM     = 4,
    parameter int DSIZE   = 48,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NUM-1:0]       req_tvalid,
    input  logic [NUM*DSIZE-1:0] req_tdata,
    output logic [NUM-1:0]       req_tready,
    output logic                 out_tvalid,
    output logic [DSIZE-1:0]     out_tdata,
    input  logic                 out_tready,
    input  logic                 bvalid,
    input  logic                 bready,
    input  logic                 stream_en_in,
    output logic [NUM-1:0]       stream_en_out,
    output logic [NUM-1:0]       grant,
    output logic                 timeout_err
);

    localparam int PW = $clog2(NUM);
    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM);

    arb_state_e     state_q, state_d;
    logic [NUM-1:0] grant_q, grant_d;
    logic [PW-1:0]  idx_q, idx_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NUM-1:0] pick_s;
    logic [PW-1:0]  pick_idx_s;
    logic [PW-1:0]  next_ptr_s;

`ifdef AXI4_WR_AUX_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT) + 1;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout_q, timeout_d;
`endif

    rr_pick #(.NUM(NUM), .PW(PW)) u_rr_pick (
        .req (req_tvalid),
        .ptr (ptr_q),
        .gnt (pick_s)
    );

    // Winner index from the one-hot pick, and the pointer value after the current owner.
    always_comb begin
        pick_idx_s = {PW{1'b0}};
        for (int k = 0; k < NUM; k++) begin
            pick_idx_s = pick_idx_s | (PW'(k) & {PW{pick_s[k]}});
        end
        next_ptr_s = PW'(rr_next(IDX_W'(idx_q), NUM_W));
    end

    // Output decode: the owner's lane is routed only while a burst is in flight.
    always_comb begin
        out_tvalid    = (state_q == ST_SEND) & req_tvalid[idx_q];
        out_tdata     = {DSIZE{1'b0}};
        for (int k = 0; k < NUM; k++) begin
            out_tdata = out_tdata |
                        (req_tdata[k*DSIZE +: DSIZE] & {DSIZE{(state_q == ST_SEND) && (idx_q == PW'(k))}});
        end
        req_tready    = (state_q == ST_SEND) ? (grant_q & {NUM{out_tready}}) : {NUM{1'b0}};
        stream_en_out = (state_q != ST_IDLE) ? (grant_q & {NUM{stream_en_in}}) : {NUM{1'b0}};
        grant         = grant_q;
`ifdef AXI4_WR_AUX_ARB_TIMEOUT_EN
        timeout_err   = timeout_q;
`else
        timeout_err   = 1'b0;
`endif
    end

    // Next-state logic: arbitrate in IDLE, hold the grant through SEND, release on response.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
`ifdef AXI4_WR_AUX_ARB_TIMEOUT_EN
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_tvalid) begin
                    state_d = ST_SEND;
                    grant_d = pick_s;
                    idx_d   = pick_idx_s;
                end else begin
                    grant_d = {NUM{1'b0}};
                end
            end
            ST_SEND: begin
                if (out_tvalid && out_tready) begin
                    state_d = ST_WAIT_RESP;
`ifdef AXI4_WR_AUX_ARB_TIMEOUT_EN
                    wdog_d  = {WW{1'b0}};
`endif
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT_RESP: begin
                if (bvalid && bready) begin
                    state_d = ST_IDLE;
                    grant_d = {NUM{1'b0}};
                    ptr_d   = next_ptr_s;
                end else begin
`ifdef AXI4_WR_AUX_ARB_TIMEOUT_EN
                    if (wdog_q == WW'(TIMEOUT - 1)) begin
                        state_d   = ST_IDLE;
                        grant_d   = {NUM{1'b0}};
                        ptr_d     = next_ptr_s;
                        timeout_d = 1'b1;
                    end else begin
                        wdog_d    = wdog_q + WW'(1);
                    end
`else
                    state_d = ST_WAIT_RESP;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NUM{1'b0}};
            end
        endcase
    end

    // Arbitration state, owner and round-robin pointer.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= {NUM{1'b0}};
            idx_q   <= {PW{1'b0}};
            ptr_q   <= {PW{1'b0}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef AXI4_WR_AUX_ARB_TIMEOUT_EN
    // Response watchdog counter and its one-cycle error pulse.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= {WW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_axi4_wr_aux_arbiter.sv
// Self-checking bench for axi4_wr_aux_arbiter: directed scenarios pinned with
// literal expectations plus randomized traffic against a transaction-level model.
module tb_axi4_wr_aux_arbiter;

    localparam int NUM     = 4;
    localparam int DSIZE   = 48;
    localparam int TIMEOUT = 16;
`ifdef AXI4_WR_AUX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 rst_n;
    logic [NUM-1:0]       req_tvalid;
    logic [NUM*DSIZE-1:0] req_tdata;
    logic [NUM-1:0]       req_tready;
    logic                 out_tvalid;
    logic [DSIZE-1:0]     out_tdata;
    logic                 out_tready;
    logic                 bvalid;
    logic                 bready;
    logic                 stream_en_in;
    logic [NUM-1:0]       stream_en_out;
    logic [NUM-1:0]       grant;
    logic                 timeout_err;

    always #5 clock = ~clock;

    axi4_wr_aux_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .TIMEOUT(TIMEOUT)) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .req_tvalid    (req_tvalid),
        .req_tdata     (req_tdata),
        .req_tready    (req_tready),
        .out_tvalid    (out_tvalid),
        .out_tdata     (out_tdata),
        .out_tready    (out_tready),
        .bvalid        (bvalid),
        .bready        (bready),
        .stream_en_in  (stream_en_in),
        .stream_en_out (stream_en_out),
        .grant         (grant),
        .timeout_err   (timeout_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: owner (-1 = nobody), whether its request was already accepted,
    // round-robin pointer, response wait counter and pending timeout pulse.
    int m_owner;
    bit m_sent;
    int m_ptr;
    int m_wcnt;
    bit m_to;

    task automatic chk(input string name, input logic [DSIZE-1:0] act, input logic [DSIZE-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_sent  = 1'b0;
        m_ptr   = 0;
        m_wcnt  = 0;
        m_to    = 1'b0;
    endtask

    task automatic compare_model();
        logic [NUM-1:0] e_grant;
        logic [NUM-1:0] e_rdy;
        logic [NUM-1:0] e_sen;
        logic           e_ov;
        e_grant = '0;
        e_rdy   = '0;
        e_sen   = '0;
        e_ov    = 1'b0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_sen[m_owner]   = stream_en_in;
            if (!m_sent) begin
                e_rdy[m_owner] = out_tready;
                e_ov           = req_tvalid[m_owner];
            end
        end
        chk("grant", grant, e_grant);
        chk("out_tvalid", out_tvalid, e_ov);
        chk("req_tready", req_tready, e_rdy);
        chk("stream_en_out", stream_en_out, e_sen);
        chk("timeout_err", timeout_err, m_to);
        if (m_owner >= 0 && !m_sent) begin
            chk("out_tdata", out_tdata, req_tdata[m_owner*DSIZE +: DSIZE]);
        end
    endtask

    task automatic model_edge();
        bit to_now;
        to_now = 1'b0;
        if (m_owner < 0) begin
            if (|req_tvalid) begin
                for (int i = 0; i < NUM; i++) begin
                    if (req_tvalid[(m_ptr + i) % NUM]) begin
                        m_owner = (m_ptr + i) % NUM;
                        break;
                    end
                end
                m_sent = 1'b0;
            end
        end else if (!m_sent) begin
            if (req_tvalid[m_owner] && out_tready) begin
                m_sent = 1'b1;
                m_wcnt = 0;
            end
        end else if (bvalid && bready) begin
            m_ptr   = (m_owner + 1) % NUM;
            m_owner = -1;
        end else if (TO_EN && m_wcnt == TIMEOUT - 1) begin
            m_ptr   = (m_owner + 1) % NUM;
            m_owner = -1;
            to_now  = 1'b1;
        end else begin
            m_wcnt++;
        end
        m_to = to_now;
    endtask

    task automatic cycle();
        @(negedge clock);
        compare_model();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_out_tvalid", out_tvalid, 1'b0);
        chk("rst_req_tready", req_tready, 4'b0000);
        chk("rst_stream_en_out", stream_en_out, 4'b0000);
        chk("rst_timeout_err", timeout_err, 1'b0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [NUM*DSIZE-1:0] rand_data();
        logic [NUM*DSIZE-1:0] d;
        for (int w = 0; w < NUM*DSIZE/32; w++) begin
            d[w*32 +: 32] = $urandom;
        end
        return d;
    endfunction

    initial begin
        model_reset();
        rst_n        = 1'b0;
        req_tvalid   = 4'b1111;
        req_tdata    = rand_data();
        out_tready   = 1'b1;
        bvalid       = 1'b0;
        bready       = 1'b0;
        stream_en_in = 1'b1;
        #3;
        chk("init_grant", grant, 4'b0000);
        chk("init_req_tready", req_tready, 4'b0000);
        chk("init_stream_en_out", stream_en_out, 4'b0000);
        chk("init_out_tvalid", out_tvalid, 1'b0);
        @(posedge clock);
        #1;
        rst_n        = 1'b1;
        stream_en_in = 1'b0;

        // Only requester 2 valid: grant one cycle later, handshake, pointer moves to 3.
        req_tvalid = 4'b0100;
        cycle();
        chk("r2_grant", grant, 4'b0100);
        chk("r2_req_tready", req_tready, 4'b0100);
        chk("r2_out_tvalid", out_tvalid, 1'b1);
        chk("r2_out_tdata", out_tdata, req_tdata[2*DSIZE +: DSIZE]);
        cycle();
        chk("r2_wait_out_tvalid", out_tvalid, 1'b0);
        chk("r2_wait_grant", grant, 4'b0100);
        bvalid = 1'b1; bready = 1'b1; req_tvalid = 4'b0000;
        cycle();
        chk("r2_idle_grant", grant, 4'b0000);
        chk("r2_model_ptr", m_ptr, 3);
        bvalid = 1'b0; req_tvalid = 4'b1111;
        cycle();
        chk("ptr3_grant", grant, 4'b1000);

        // All requesting, immediate responses: rotation wraps back to 0.
        bvalid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            logic [NUM-1:0] exp_g;
            exp_g = 4'b0001 << (n % NUM);
            cycle(); cycle(); cycle();
            chk("rotate_grant", grant, exp_g);
        end

        // Generator stalls for 5 cycles: grant held, no ready.
        bvalid = 1'b0; out_tready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("stall_grant", grant, 4'b0001);
            chk("stall_req_tready", req_tready, 4'b0000);
        end
        out_tready = 1'b1;
        cycle();
        bvalid = 1'b1; req_tvalid = 4'b0000;
        cycle();
        bvalid = 1'b0; req_tvalid = 4'b1111;
        cycle();
        chk("se_grant", grant, 4'b0010);
        cycle();
        stream_en_in = 1'b1;
        #1;
        chk("se_wait_stream_en_out", stream_en_out, 4'b0010);
        bvalid = 1'b1; req_tvalid = 4'b0000;
        cycle();
        chk("se_idle_stream_en_out", stream_en_out, 4'b0000);

        // Reset in the middle of WAIT_RESP.
        bvalid = 1'b0; req_tvalid = 4'b1111;
        cycle();
        chk("pre_rst_grant", grant, 4'b0100);
        cycle();
        do_reset();
        req_tvalid = 4'b0110;
        cycle();
        chk("post_rst_grant", grant, 4'b0010);

        // Response never arrives.
        cycle();
        req_tvalid = 4'b0000;
        for (int n = 0; n < TIMEOUT - 1; n++) begin
            cycle();
            chk("wd_quiet", timeout_err, 1'b0);
        end
        cycle();
`ifdef AXI4_WR_AUX_ARB_TIMEOUT_EN
        chk("wd_pulse", timeout_err, 1'b1);
        chk("wd_grant", grant, 4'b0000);
        req_tvalid = 4'b1111;
        cycle();
        chk("wd_pulse_end", timeout_err, 1'b0);
        chk("wd_next_grant", grant, 4'b0100);
`else
        chk("nowd_grant", grant, 4'b0010);
        chk("nowd_timeout_err", timeout_err, 1'b0);
        bvalid = 1'b1;
        cycle();
        chk("nowd_release", grant, 4'b0000);
`endif

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            req_tvalid   = NUM'($urandom_range(0, 15));
            req_tdata    = rand_data();
            out_tready   = ($urandom_range(0, 3) != 0);
            bvalid       = ($urandom_range(0, 11) == 0);
            bready       = ($urandom_range(0, 1) == 1);
            stream_en_in = ($urandom_range(0, 1) == 1);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi4_wr_aux_arbiter.md
AXI4_WR_AUX_ARBITER -- requirements
Module: axi4_wr_aux_arbiter

Interface
REQ-001 Parameter NUM, default 4: number of requesters (2..16).
REQ-002 Parameter DSIZE, default 48: width of one {id,addr,len} request word.
REQ-003 Parameter TIMEOUT, default 4096: watchdog limit in cycles for the response wait.
REQ-004 clock  input  1  sole clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req_tvalid  input  NUM  per-requester request valid.
REQ-007 req_tdata  input  NUM*DSIZE  per-requester {id,addr,len}; requester k occupies bits [k*DSIZE +: DSIZE].
REQ-008 req_tready  output  NUM  per-requester request ready.
REQ-009 out_tvalid  output  1  forwarded request valid, to the wr-aux generator.
REQ-010 out_tdata  output  DSIZE  forwarded request word.
REQ-011 out_tready  input  1  generator ready.
REQ-012 bvalid, bready  input  1 each  monitored write-response handshake; the block never drives these signals.
REQ-013 stream_en_in  input  1  data-enable from the generator.
REQ-014 stream_en_out  output  NUM  data-enable routed to the granted requester only.
REQ-015 grant  output  NUM  one-hot current owner; all zero when idle.
REQ-016 timeout_err  output  1  one-cycle pulse when the watchdog fires (macro only; otherwise tied 0).

Function
REQ-017 States: IDLE, SEND and WAIT_RESP. Only one burst may be outstanding at any time.
REQ-018 IDLE: when any req_tvalid is high, register the round-robin winner into grant and go to SEND on the next edge. Arbitration takes 1 cycle.
REQ-019 Round-robin search starts at index ptr and increases modulo NUM. ptr resets to 0.
REQ-020 SEND: out_tvalid = req_tvalid[g] and out_tdata = req_tdata slice g. req_tready[g] = out_tready; every other req_tready is 0.
REQ-021 SEND: on out_tvalid && out_tready, go to WAIT_RESP. The grant does not change until then, even if req_tvalid[g] drops.
REQ-022 WAIT_RESP: on bvalid && bready, go to IDLE and set ptr = (g+1) mod NUM (wrap from NUM-1 to 0).
REQ-023 When the b handshake and a new request arrive in the same cycle, the new request waits. Re-arbitration happens in IDLE on the next cycle, so there are at least 2 cycles between bursts.
REQ-024 stream_en_out[g] = stream_en_in in SEND and WAIT_RESP; stream_en_out is 0 for all other bits and in IDLE. This path is combinational.
REQ-025 req_tready and out_tvalid are 0 in IDLE and WAIT_RESP.

Reset
REQ-026 Asserting rst_n low at any time forces IDLE. It also forces grant=0, ptr=0, out_tvalid=0, req_tready=0, stream_en_out=0, timeout_err=0 and watchdog=0, including when reset arrives mid-burst.

Configuration
REQ-027 With AXI4_WR_AUX_ARB_TIMEOUT_EN defined, a counter runs in WAIT_RESP and clears on entry to that state.
REQ-028 When that counter reaches TIMEOUT-1 with no b handshake, the block pulses timeout_err for 1 cycle, returns to IDLE and advances ptr.
REQ-029 Without AXI4_WR_AUX_ARB_TIMEOUT_EN, there is no counter, timeout_err = 0, and WAIT_RESP waits indefinitely.

Structure
REQ-030 A shared package axi4_wr_aux_arb_pkg holds the state enum and the round-robin next-index function.
REQ-031 The round-robin selector is one sub-module, rr_pick (NUM-wide request plus ptr in, one-hot out, purely combinational).

Verification
REQ-032 NUM=4, only req 2 valid, out_tready=1 -> grant=0100 one cycle after valid, handshake in SEND, ptr=3 after bvalid&bready.
REQ-033 All 4 requesting continuously, responses immediate -> grant sequence 0001,0010,0100,1000,0001 (wrap verified).
REQ-034 out_tready held 0 for 5 cycles in SEND -> grant stable, req_tready[g]=0 throughout, no state change.
REQ-035 stream_en_in=1 in WAIT_RESP with grant=0010 -> stream_en_out=0010; stream_en_out=0000 in IDLE.
REQ-036 rst_n pulsed low during WAIT_RESP -> all outputs 0 immediately, ptr=0, first grant after release goes to lowest valid index.
REQ-037 With the macro, TIMEOUT=16 and no bvalid -> timeout_err pulses 16 cycles after entering WAIT_RESP, state=IDLE, ptr advanced.
